// File: rtl/fpga_conf_rx.sv
// Configuration receiver: deserialises 16-bit SPI command words from the ARM
// (oversampled in the ck_1356meg domain) into persistent configuration registers.
module fpga_conf_rx #(
    parameter int          FRAME_BITS = 16,
    parameter logic [7:0]  DIV_RESET  = 8'd95
) (
    input  logic        ck_1356meg,
    input  logic        reset,
    input  logic        spck,
    input  logic        mosi,
    input  logic        ncs,
    output logic [11:0] conf_word,
    output logic [2:0]  major_mode,
    output logic [7:0]  divisor,
    output logic        cmd_strobe,
    output logic        mode_change,
    output logic        frame_err
);

    localparam logic [4:0]  CNT_FRAME = 5'(FRAME_BITS);
    localparam logic [4:0]  CNT_SAT   = 5'(FRAME_BITS + 1);
    localparam logic [11:0] CONF_RESET = 12'h1C0;
    localparam logic [3:0]  OP_SET_CONFREG = 4'h1;
    localparam logic [3:0]  OP_SET_DIVISOR = 4'h2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_t;

    // Handshake: none. A frame is one ncs low period; data is sampled on
    // spck rising edges and committed only when ncs rises after exactly
    // FRAME_BITS edges. Pulse outputs are single-cycle, registered.

    state_t      state, state_nx;
    logic [15:0] shreg, shreg_nx;
    logic [4:0]  bit_cnt, bit_cnt_nx;
    logic [11:0] conf_nx;
    logic [7:0]  div_nx;
    logic        strobe_nx, mc_nx, err_nx;

    logic spck_m, spck_s, spck_d;
    logic mosi_m, mosi_s;
    logic ncs_m, ncs_s, ncs_d;
    logic spck_rise, ncs_rise, ncs_fall;

    // ncs sync flops reset low so a frame already in progress when reset
    // releases never shows a falling edge and is dropped silently.
    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            spck_m <= 1'b0;
            spck_s <= 1'b0;
            spck_d <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
            ncs_m  <= 1'b0;
            ncs_s  <= 1'b0;
            ncs_d  <= 1'b0;
        end else begin
            spck_m <= spck;
            spck_s <= spck_m;
            spck_d <= spck_s;
            mosi_m <= mosi;
            mosi_s <= mosi_m;
            ncs_m  <= ncs;
            ncs_s  <= ncs_m;
            ncs_d  <= ncs_s;
        end
    end

    assign spck_rise = spck_s & ~spck_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    assign major_mode = conf_word[8:6];

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        conf_nx    = conf_word;
        div_nx     = divisor;
        strobe_nx  = 1'b0;
        mc_nx      = 1'b0;
        err_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    state_nx   = SHIFT;
                    shreg_nx   = '0;
                    bit_cnt_nx = '0;
                end
            end
            SHIFT: begin
                // ncs edge wins over a coincident spck edge: that bit is not shifted.
                if (ncs_rise) begin
                    state_nx = DECODE;
                    if (bit_cnt == CNT_FRAME) begin
                        strobe_nx = 1'b1;
                        case (shreg[15:12])
                            OP_SET_CONFREG: begin
                                conf_nx = shreg[11:0];
                                mc_nx   = (shreg[8:6] != conf_word[8:6]);
                            end
                            OP_SET_DIVISOR: div_nx = shreg[7:0];
                            default: ;
                        endcase
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (spck_rise) begin
                    shreg_nx = {shreg[14:0], mosi_s};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt_nx = bit_cnt + 5'd1;
                    end
                end
            end
            DECODE: begin
                if (ncs_fall) begin
                    state_nx   = SHIFT;
                    shreg_nx   = '0;
                    bit_cnt_nx = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            conf_word   <= CONF_RESET;
            divisor     <= DIV_RESET;
            cmd_strobe  <= 1'b0;
            mode_change <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            shreg       <= shreg_nx;
            bit_cnt     <= bit_cnt_nx;
            conf_word   <= conf_nx;
            divisor     <= div_nx;
            cmd_strobe  <= strobe_nx;
            mode_change <= mc_nx;
            frame_err   <= err_nx;
        end
    end

endmodule

// File: tb/tb_fpga_conf_rx.sv
// Directed bench for fpga_conf_rx: drives SPI frames at spck = ck/4 and checks
// registers and pulse timing against hand-computed values.
module tb_fpga_conf_rx;

    logic        clk;
    logic        reset;
    logic        spck;
    logic        mosi;
    logic        ncs;
    logic [11:0] conf_word;
    logic [2:0]  major_mode;
    logic [7:0]  divisor;
    logic        cmd_strobe;
    logic        mode_change;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    fpga_conf_rx dut (
        .ck_1356meg (clk),
        .reset      (reset),
        .spck       (spck),
        .mosi       (mosi),
        .ncs        (ncs),
        .conf_word  (conf_word),
        .major_mode (major_mode),
        .divisor    (divisor),
        .cmd_strobe (cmd_strobe),
        .mode_change(mode_change),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            spck = 1'b0;
            cycles(2);
            spck = 1'b1;
            cycles(2);
        end
        spck = 1'b0;
        cycles(2);
    endtask

    // Called right after ncs is raised at a negedge: pulses must appear only
    // in the third sampled half-period (registered two edges after sampling).
    task automatic check_window(input logic es, input logic em, input logic ee);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("cmd_strobe_w%0d", k), {15'd0, cmd_strobe},  {15'd0, (k == 2) ? es : 1'b0});
            check($sformatf("mode_change_w%0d", k), {15'd0, mode_change}, {15'd0, (k == 2) ? em : 1'b0});
            check($sformatf("frame_err_w%0d", k), {15'd0, frame_err},   {15'd0, (k == 2) ? ee : 1'b0});
        end
    endtask

    task automatic frame(input logic [31:0] data, input int nbits,
                         input logic es, input logic em, input logic ee);
        ncs = 1'b0;
        cycles(3);
        send_bits(data, nbits);
        ncs = 1'b1;
        check_window(es, em, ee);
        cycles(2);
    endtask

    task automatic check_regs(input string tag, input logic [11:0] c, input logic [7:0] d);
        check({tag, "_conf"},  {4'd0, conf_word},   {4'd0, c});
        check({tag, "_major"}, {13'd0, major_mode}, {13'd0, c[8:6]});
        check({tag, "_div"},   {8'd0, divisor},     {8'd0, d});
    endtask

    initial begin
        reset = 1'b1;
        spck  = 1'b0;
        mosi  = 1'b0;
        ncs   = 1'b1;
        cycles(4);
        reset = 1'b0;
        cycles(6);

        // Reset state, idle bus
        check_regs("reset", 12'h1C0, 8'd95);
        check("reset_major7", {13'd0, major_mode}, 16'd7);
        check("reset_strobe", {15'd0, cmd_strobe}, 16'd0);
        check("reset_mc", {15'd0, mode_change}, 16'd0);
        check("reset_err", {15'd0, frame_err}, 16'd0);

        // SET_CONFREG 0x083: major 7 -> 2
        frame(32'h1083, 16, 1'b1, 1'b1, 1'b0);
        check_regs("confreg1", 12'h083, 8'd95);
        check("confreg1_major2", {13'd0, major_mode}, 16'd2);

        // Same major bits: no mode_change
        frame(32'h10BF, 16, 1'b1, 1'b0, 1'b0);
        check_regs("confreg2", 12'h0BF, 8'd95);

        // SET_DIVISOR
        frame(32'h2007, 16, 1'b1, 1'b0, 1'b0);
        check_regs("divisor", 12'h0BF, 8'd7);

        // Unknown opcode: strobe only
        frame(32'h5ABC, 16, 1'b1, 1'b0, 1'b0);
        check_regs("unknown_op", 12'h0BF, 8'd7);

        // 15-bit frame, then valid frame
        frame(32'h0FE0, 15, 1'b0, 1'b0, 1'b1);
        check_regs("short_frame", 12'h0BF, 8'd7);
        frame(32'h11C0, 16, 1'b1, 1'b1, 1'b0);
        check_regs("after_short", 12'h1C0, 8'd7);

        // 20-bit frame, then valid frame
        frame(32'h12345, 20, 1'b0, 1'b0, 1'b1);
        check_regs("long_frame", 12'h1C0, 8'd7);
        frame(32'h2033, 16, 1'b1, 1'b0, 1'b0);
        check_regs("after_long", 12'h1C0, 8'h33);

        // Reset after 8 bits of a SET_CONFREG; rest of frame must be ignored
        ncs = 1'b0;
        cycles(3);
        send_bits(32'h10, 8);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        send_bits(32'h83, 8);
        ncs = 1'b1;
        check_window(1'b0, 1'b0, 1'b0);
        cycles(2);
        check_regs("midreset", 12'h1C0, 8'd95);

        frame(32'h1083, 16, 1'b1, 1'b1, 1'b0);
        check_regs("after_midreset", 12'h083, 8'd95);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
